alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter data_size, default 8: width of operands, result and accumulator.
REQ-002 Parameter op_code_size, default 3: width of op code fields.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 cmd_valid  input  1: command present.
REQ-006 cmd_ready  output  1: sequencer accepts a command this cycle.
REQ-007 cmd_op  input  op_code_size: arithmetic op code to issue.
REQ-008 cmd_a  input  data_size: A operand, used when cmd_acc_sel=0.
REQ-009 cmd_b  input  data_size: B operand.
REQ-010 cmd_acc_sel  input  1: 1 = A operand taken from the accumulator instead of cmd_a.
REQ-011 cmd_clr_carry  input  1: 1 = clear the carry flag before issuing.
REQ-012 alu_op  output  op_code_size: op code driven to the arithmetic unit.
REQ-013 alu_a, alu_b  output  data_size each: operands driven to the arithmetic unit.
REQ-014 alu_cin  output  1: carry driven to the arithmetic unit.
REQ-015 alu_result  input  data_size: combinational result from the arithmetic unit.
REQ-016 alu_cout  input  1: combinational carry/borrow from the arithmetic unit.
REQ-017 rsp_valid  output  1: response available.
REQ-018 rsp_ready  input  1: consumer accepts the response.
REQ-019 rsp_result  output  data_size; rsp_carry  output  1: captured result and carry.

Function
REQ-020 FSM states IDLE, ISSUE, CAPTURE, RESP; encoding free.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 at a clock edge.
REQ-022 On acceptance: register op, B, A (accumulator if cmd_acc_sel else cmd_a); if cmd_clr_carry, carry flag <= 0 at that edge; FSM IDLE->ISSUE.
REQ-023 alu_op/alu_a/alu_b SHALL be driven only from registers, stable from ISSUE through CAPTURE; alu_cin SHALL equal the carry flag register.
REQ-024 ISSUE lasts exactly one cycle (settling cycle); ISSUE->CAPTURE unconditionally.
REQ-025 At the CAPTURE edge: accumulator <= alu_result, carry flag <= alu_cout, rsp_result/rsp_carry <= same values; FSM CAPTURE->RESP.
REQ-026 rsp_valid SHALL be 1 exactly in RESP; rsp_result/rsp_carry stable while rsp_valid=1.
REQ-027 RESP->IDLE at the edge where rsp_ready=1; rsp_ready=0 holds RESP indefinitely; no new command accepted meanwhile.
REQ-028 Latency: acceptance edge N, rsp_valid high from cycle N+3; with rsp_ready tied 1, one command per 4 cycles.
REQ-029 Carry flag persists across commands (enables multi-word add/sub chaining via op 010/100) until overwritten by CAPTURE or cleared by cmd_clr_carry.
REQ-030 cmd_clr_carry and acceptance in the same cycle: cleared flag is the alu_cin used for that command.
REQ-031 All op codes, including reserved 111, are issued unmodified; sequencer applies no op-specific behaviour.
REQ-032 rsp_ready asserted outside RESP SHALL be ignored; cmd_valid outside IDLE SHALL be ignored (inputs not registered).

Reset
REQ-033 rst_n=0 SHALL immediately force: FSM IDLE, cmd_ready=1, rsp_valid=0, accumulator=0, carry flag=0, rsp_result=0, rsp_carry=0, alu_op=0, alu_a=0, alu_b=0, alu_cin=0.
REQ-034 Reset in any state aborts the command in flight; no response is produced for it.

Verification (bench models the arithmetic unit: 000 pass A, 001 A+B, 010 A+B+cin, 011 A-B, 100 A-B-cin, 101 A+1, 110 A-1, 111 zero; carry = bit data_size of 9-bit result)
REQ-035 op 001, a=0xF0, b=0x20, rsp_ready=1 -> rsp_valid at N+3, rsp_result=0x10, rsp_carry=1, cmd_ready low N+1..N+3.
REQ-036 16-bit chain: op 001 a=0xFF b=0x01 (clr_carry) then op 010 a=0x00 b=0x00 -> responses 0x00/c1 then 0x01/c0.
REQ-037 op 011 a=0x00 b=0x01 -> 0xFF, carry 1; next op 101 with acc_sel=1 -> 0x00, carry 1.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, cmd_valid ignored, then single handshake returns to IDLE.
REQ-039 rst_n pulsed low during ISSUE and again during RESP -> all outputs at reset values immediately, no response, next command processed normally with carry flag 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one command at a time to an external arithmetic unit.
// Ports: cmd_* (valid/ready in), alu_* (to/from arithmetic unit), rsp_* (valid/ready out).
module alu_sequencer #(
  parameter int data_size    = 8,
  parameter int op_code_size = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [op_code_size-1:0] cmd_op,
  input  logic [data_size-1:0]    cmd_a,
  input  logic [data_size-1:0]    cmd_b,
  input  logic                    cmd_acc_sel,
  input  logic                    cmd_clr_carry,
  output logic [op_code_size-1:0] alu_op,
  output logic [data_size-1:0]    alu_a,
  output logic [data_size-1:0]    alu_b,
  output logic                    alu_cin,
  input  logic [data_size-1:0]    alu_result,
  input  logic                    alu_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [data_size-1:0]    rsp_result,
  output logic                    rsp_carry
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [op_code_size-1:0] op_q;
  logic [data_size-1:0]    a_q;
  logic [data_size-1:0]    b_q;
  logic [data_size-1:0]    acc_q;
  logic [data_size-1:0]    res_q;
  logic                    carry_q;
  logic                    rcarry_q;
  logic                    accept;

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign accept     = cmd_valid & cmd_ready;

  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_cin    = carry_q;
  assign rsp_result = res_q;
  assign rsp_carry  = rcarry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Carry survives between commands so multi-word add/sub can chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      rcarry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= cmd_op;
        a_q  <= cmd_acc_sel ? acc_q : cmd_a;
        b_q  <= cmd_b;
        if (cmd_clr_carry) carry_q <= 1'b0;
      end
      if (state_q == CAPTURE) begin
        acc_q    <= alu_result;
        carry_q  <= alu_cout;
        res_q    <= alu_result;
        rcarry_q <= alu_cout;
      end
    end
  end

endmodule
